rv_rf_wb_arbiter: RTL

//  Shares the register file's single write port between NREQ writeback producers (ALU, LSU, AES unit).
//  - Arbitration is round-robin.
//  - The winner's write is registered and driven onto the regfile write port (we/waddr/wdata) one cycle later.
//  - An optional scoreboard tracks issued-but-unwritten destinations so decode can stall on RAW hazards.

---
 rtl/rv_rf_wb_arbiter_pkg.sv | 30 +++
 rtl/rv_rf_wb_arbiter_arb.sv | 64 ++++++
 rtl/rv_rf_wb_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/rv_rf_wb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rv_rf_wb_arbiter_pkg
//   Shared constants and helpers for the register-file writeback arbiter.
//   - RF_AW / NREGS   : register-file address width and register count
//   - BUS_W_DEFAULT   : default datapath width
//   - WB_ALU/LSU/AES  : fixed requester indices on the writeback bus
//   - rf_onehot()     : decode a register address into a 32-bit one-hot mask
// ----------------------------------------------------------------------------
package rv_rf_wb_arbiter_pkg;

    localparam int RF_AW         = 5;
    localparam int NREGS         = 32;
    localparam int BUS_W_DEFAULT = 32;

    // Requester slot assignment on the writeback bus.
    localparam int WB_ALU = 0;
    localparam int WB_LSU = 1;
    localparam int WB_AES = 2;

    typedef logic [RF_AW-1:0] rf_addr_t;

    // One-hot decode of a register index, used for scoreboard set/clear masks.
    function automatic logic [NREGS-1:0] rf_onehot(input rf_addr_t addr);
        logic [NREGS-1:0] mask;
        mask       = '0;
        mask[addr] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/rv_rf_wb_arbiter_arb.sv
// ----------------------------------------------------------------------------
// rv_rr_arbiter
//   Round-robin arbiter with a rotating priority pointer.
//   The scan starts at rr_ptr and wraps modulo N; the first requesting index
//   wins. After a grant the pointer moves to the slot after the winner, so a
//   continuously requesting index is served within N cycles. With no grant
//   the pointer holds.
// Ports
//   clk  in  1   clock
//   rst  in  1   synchronous active-high reset (rr_ptr -> 0)
//   en   in  1   grant enable; when low gnt is all-zero and rr_ptr holds
//   req  in  N   request vector
//   gnt  out N   one-hot grant (combinational), subset of req
// ----------------------------------------------------------------------------
module rv_rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt
);

    localparam int         PW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW:0] N_W  = (PW+1)'(N);

    logic [PW-1:0] rr_ptr_q;
    logic [PW-1:0] rr_ptr_d;
    logic [PW:0]   idx;
    logic          found;

    always_comb begin
        gnt      = '0;
        rr_ptr_d = rr_ptr_q;
        found    = 1'b0;
        idx      = '0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                // Candidate index = (rr_ptr + k) mod N; one extra bit avoids
                // overflow before the wrap subtraction.
                idx = {1'b0, rr_ptr_q} + (PW+1)'(k);
                if (idx >= N_W) begin
                    idx = idx - N_W;
                end
                if (!found && req[idx[PW-1:0]]) begin
                    found               = 1'b1;
                    gnt[idx[PW-1:0]]    = 1'b1;
                    rr_ptr_d            = (idx == N_W - 1'b1) ? '0
                                                              : idx[PW-1:0] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/rv_rf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// rv_rf_wb_arbiter
//   Shares the register file's single write port between NREQ writeback
//   producers (ALU, LSU, AES). A round-robin arbiter picks one valid
//   requester per cycle; the winner's write is registered and presented on
//   rf_we/rf_waddr/rf_wdata the following cycle. Writes to x0 are granted
//   (so the producer is released and the pointer advances) but never reach
//   the register file.
//
//   Optional RAW scoreboard, compiled in with macro RV_WB_SCOREBOARD_EN:
//   tracks destinations that have issued but not yet been written so decode
//   can stall. Without the macro rs1_busy/rs2_busy are tied low and the
//   issue_* / raddr* inputs are ignored (ports stay for a uniform interface).
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   per-requester handshake, ready is one-hot & comb.
//   req_waddr/req_wdata   packed per-requester address (5b) and data slices
//   flush                 blocks grants this cycle, clears the scoreboard
//   issue_valid/issue_rd  instruction issued with destination issue_rd
//   raddr1/raddr2         decode source queries
//   rs1_busy/rs2_busy     source has a pending write
//   rf_we/rf_waddr/rf_wdata  registered register-file write port
// ----------------------------------------------------------------------------
module rv_rf_wb_arbiter
    import rv_rf_wb_arbiter_pkg::*;
#(
    parameter int NREQ  = WB_AES + 1,
    parameter int BUS_W = BUS_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*5-1:0]     req_waddr,
    input  logic [NREQ*BUS_W-1:0] req_wdata,
    input  logic                  flush,
    input  logic                  issue_valid,
    input  logic [4:0]            issue_rd,
    input  logic [4:0]            raddr1,
    input  logic [4:0]            raddr2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  rf_we,
    output logic [4:0]            rf_waddr,
    output logic [BUS_W-1:0]      rf_wdata
);

    // ------------------------------------------------------------------
    // Unpack the per-requester buses
    // ------------------------------------------------------------------
    rf_addr_t         waddr_arr [NREQ];
    logic [BUS_W-1:0] wdata_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign waddr_arr[gi] = req_waddr[gi*RF_AW +: RF_AW];
        assign wdata_arr[gi] = req_wdata[gi*BUS_W +: BUS_W];
    end

    // ------------------------------------------------------------------
    // Arbitration: no grants while flushing or in reset
    // ------------------------------------------------------------------
    logic [NREQ-1:0] gnt;
    logic            arb_en;

    assign arb_en = ~rst & ~flush;

    rv_rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .en  (arb_en),
        .req (req_valid),
        .gnt (gnt)
    );

    assign req_ready = gnt;

    // One-hot select of the winning requester's address/data.
    rf_addr_t         sel_addr;
    logic [BUS_W-1:0] sel_data;
    logic             any_gnt;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_addr = waddr_arr[i];
                sel_data = wdata_arr[i];
            end
        end
    end

    assign any_gnt = |gnt;

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    logic             rf_we_q,    rf_we_d;
    rf_addr_t         rf_waddr_q, rf_waddr_d;
    logic [BUS_W-1:0] rf_wdata_q, rf_wdata_d;

    // An x0 grant is treated like no write at all: the enable drops and the
    // address/data registers keep their last committed values.
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (any_gnt && (sel_addr != '0)) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = sel_addr;
            rf_wdata_d = sel_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

    // ------------------------------------------------------------------
    // RAW scoreboard
    // ------------------------------------------------------------------
`ifdef RV_WB_SCOREBOARD_EN
    logic [NREGS-1:0] busy_q, busy_d;
    logic [NREGS-1:0] set_mask, clr_mask;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_valid && (issue_rd != '0)) begin
            set_mask = rf_onehot(issue_rd);
        end
        if (rf_we_q) begin
            clr_mask = rf_onehot(rf_waddr_q);
        end
        // Clear first, then set, so an issue to a register that commits in
        // the same cycle leaves it busy (the new producer is still pending).
        busy_d = (busy_q & ~clr_mask) | set_mask;
        if (flush) begin
            busy_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // The regfile forwards the value being written this cycle, so a source
    // matching the committing write is not reported busy.
    assign rs1_busy = busy_q[raddr1] & (raddr1 != '0)
                    & ~(rf_we_q & (rf_waddr_q == raddr1));
    assign rs2_busy = busy_q[raddr2] & (raddr2 != '0)
                    & ~(rf_we_q & (rf_waddr_q == raddr2));
`else
    logic unused_sb_inputs;
    assign unused_sb_inputs = ^{issue_valid, issue_rd, raddr1, raddr2};

    assign rs1_busy = 1'b0;
    assign rs2_busy = 1'b0;
`endif

endmodule
